// File: rtl/kronos_tohost_monitor.sv
// kronos_tohost_monitor: passive end-of-test monitor snooping core 0's data bus.
//
// Watches for the compliance "tohost" store and decodes its value:
//   1 = pass, odd != 1 = fail (code = value >> 1), even = ignored.
// Also counts cycles and instruction fetches while the test runs and fires a
// watchdog after TIMEOUT_CYCLES cycles (0 disables it). Results are sticky
// until reset so the harness can sample them and stop at its leisure.
//
// Optional build macro: KRONOS_TOHOST_SIG_CRC_EN
//   When defined, full-word stores into [SIG_BEGIN, SIG_END) are folded into a
//   reflected CRC-32 reported on sig_crc_o. When undefined, sig_crc_o is 0.
//
// Ports:
//   clk_i           core clock
//   rstz_i          synchronous active-low reset
//   data_addr_i     snooped data address
//   data_wr_data_i  snooped write data
//   data_mask_i     snooped byte mask
//   data_wr_en_i    snooped write enable
//   data_req_i      snooped request
//   data_ack_i      snooped acknowledge
//   instr_ack_i     snooped instruction fetch acknowledge
//   done_o          test finished (pass, fail or timeout), sticky
//   pass_o          test passed, sticky
//   timeout_o       watchdog fired, sticky
//   fail_code_o     failing test number
//   cycle_count_o   cycles spent in RUN (saturating)
//   fetch_count_o   instruction acks seen in RUN (saturating)
//   sig_crc_o       signature CRC-32 (optional feature, else 0)

module kronos_tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [31:0] SIG_BEGIN      = 32'h0000_1100,
  parameter logic [31:0] SIG_END        = 32'h0000_1200
) (
  input  logic        clk_i,
  input  logic        rstz_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wr_data_i,
  input  logic [3:0]  data_mask_i,
  input  logic        data_wr_en_i,
  input  logic        data_req_i,
  input  logic        data_ack_i,
  input  logic        instr_ack_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [30:0] fail_code_o,
  output logic [31:0] cycle_count_o,
  output logic [31:0] fetch_count_o,
  output logic [31:0] sig_crc_o
);

  localparam bit          WdEn   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0] WdLast = TIMEOUT_CYCLES - 32'd1;

  typedef enum logic [1:0] {StRun, StPass, StFail, StTimeout} state_e;

  state_e      state_q, state_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] fetch_q, fetch_d;

  logic wr_ev;
  logic tohost_ev;
  logic in_run;

  assign wr_ev     = data_req_i & data_wr_en_i & data_ack_i;
  assign tohost_ev = wr_ev && (data_addr_i == TOHOST_ADDR) && (data_mask_i == 4'hF);
  assign in_run    = (state_q == StRun);

  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    cycle_d     = cycle_q;
    fetch_d     = fetch_q;
    if (in_run) begin
      // The terminating cycle is still counted, so counters advance first.
      if (cycle_q != 32'hFFFF_FFFF) cycle_d = cycle_q + 32'd1;
      if (instr_ack_i && (fetch_q != 32'hFFFF_FFFF)) fetch_d = fetch_q + 32'd1;
      // Tohost has priority over a watchdog expiring in the same cycle.
      if (tohost_ev && data_wr_data_i[0]) begin
        if (data_wr_data_i == 32'd1) begin
          state_d = StPass;
        end else begin
          state_d     = StFail;
          fail_code_d = data_wr_data_i[31:1];
        end
      end else if (WdEn && (cycle_q == WdLast)) begin
        state_d = StTimeout;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstz_i) begin
      state_q     <= StRun;
      fail_code_q <= '0;
      cycle_q     <= '0;
      fetch_q     <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      cycle_q     <= cycle_d;
      fetch_q     <= fetch_d;
    end
  end

  assign done_o        = (state_q != StRun);
  assign pass_o        = (state_q == StPass);
  assign timeout_o     = (state_q == StTimeout);
  assign fail_code_o   = fail_code_q;
  assign cycle_count_o = cycle_q;
  assign fetch_count_o = fetch_q;

`ifdef KRONOS_TOHOST_SIG_CRC_EN
  // Reflected CRC-32 over one word: bytes LSB first, bits LSB first within each
  // byte, which is simply bit 0 through bit 31 of the word.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc_in,
                                             input logic [31:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else                c = c >> 1;
    end
    return c;
  endfunction

  logic [31:0] crc_q, crc_d;
  logic        sig_ev;

  assign sig_ev = in_run && wr_ev && (data_mask_i == 4'hF) &&
                  (data_addr_i >= SIG_BEGIN) && (data_addr_i < SIG_END);

  always_comb begin
    crc_d = crc_q;
    if (sig_ev) crc_d = crc32_word(crc_q, data_wr_data_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rstz_i) crc_q <= 32'hFFFF_FFFF;
    else         crc_q <= crc_d;
  end

  assign sig_crc_o = crc_q ^ 32'hFFFF_FFFF;
`else
  // Region bounds only matter when the CRC is built.
  logic unused_sig_range;
  assign unused_sig_range = ^{SIG_BEGIN, SIG_END};
  assign sig_crc_o        = 32'h0;
`endif

endmodule

// File: tb/tb_kronos_tohost_monitor.sv
module tb_kronos_tohost_monitor;

  localparam logic [31:0] Tohost = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rstz;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        wr_en, req, ack, iack;

  logic        done, pass, tmo;
  logic [30:0] fcode;
  logic [31:0] ccnt, fcnt, crc;

  logic        nw_done, nw_pass, nw_tmo;
  logic [30:0] nw_fcode;
  logic [31:0] nw_ccnt, nw_fcnt, nw_crc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  kronos_tohost_monitor #(
    .TIMEOUT_CYCLES (32'd20)
  ) u_dut (
    .clk_i          (clk),
    .rstz_i         (rstz),
    .data_addr_i    (addr),
    .data_wr_data_i (wdata),
    .data_mask_i    (mask),
    .data_wr_en_i   (wr_en),
    .data_req_i     (req),
    .data_ack_i     (ack),
    .instr_ack_i    (iack),
    .done_o         (done),
    .pass_o         (pass),
    .timeout_o      (tmo),
    .fail_code_o    (fcode),
    .cycle_count_o  (ccnt),
    .fetch_count_o  (fcnt),
    .sig_crc_o      (crc)
  );

  // Same stimulus, watchdog disabled.
  kronos_tohost_monitor #(
    .TIMEOUT_CYCLES (32'd0)
  ) u_dut_nw (
    .clk_i          (clk),
    .rstz_i         (rstz),
    .data_addr_i    (addr),
    .data_wr_data_i (wdata),
    .data_mask_i    (mask),
    .data_wr_en_i   (wr_en),
    .data_req_i     (req),
    .data_ack_i     (ack),
    .instr_ack_i    (iack),
    .done_o         (nw_done),
    .pass_o         (nw_pass),
    .timeout_o      (nw_tmo),
    .fail_code_o    (nw_fcode),
    .cycle_count_o  (nw_ccnt),
    .fetch_count_o  (nw_fcnt),
    .sig_crc_o      (nw_crc)
  );

  typedef struct {
    string       name;
    logic        rstz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        req, wr, ack, iack;
    logic        e_done, e_pass, e_tmo;
    logic [30:0] e_fc;
    logic [31:0] e_cc, e_fetch;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input string name, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m,
                              input logic q, input logic w, input logic k, input logic ia,
                              input logic ed, input logic ep, input logic et,
                              input logic [30:0] efc, input logic [31:0] ecc,
                              input logic [31:0] ef);
    vec_t v;
    v.name = name; v.rstz = r; v.addr = a; v.wdata = d; v.mask = m;
    v.req = q; v.wr = w; v.ack = k; v.iack = ia;
    v.e_done = ed; v.e_pass = ep; v.e_tmo = et; v.e_fc = efc; v.e_cc = ecc; v.e_fetch = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic ed, input logic ep, input logic et,
                         input logic [30:0] efc, input logic [31:0] ecc, input logic [31:0] ef);
    chk({name, ".done"}, {31'd0, done}, {31'd0, ed});
    chk({name, ".pass"}, {31'd0, pass}, {31'd0, ep});
    chk({name, ".timeout"}, {31'd0, tmo}, {31'd0, et});
    chk({name, ".fail_code"}, {1'b0, fcode}, {1'b0, efc});
    chk({name, ".cycle_count"}, ccnt, ecc);
    chk({name, ".fetch_count"}, fcnt, ef);
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic q, input logic w, input logic k,
                       input logic ia);
    rstz = r; addr = a; wdata = d; mask = m; req = q; wr_en = w; ack = k; iack = ia;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (n) step();
  endtask

  task automatic reset();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle(0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    drive(1'b1, a, d, m, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle(0);
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Each row is applied for one cycle; expectations are the post-edge values.
    vecs[0]  = mk("t_reset", 0, 0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 0, 31'd0, 0, 0);
    vecs[1]  = mk("t_fail7", 1, Tohost, 32'd7, 4'hF, 1, 1, 1, 0,  1, 0, 0, 31'd3, 1, 0);
    vecs[2]  = mk("t_late1", 1, Tohost, 32'd1, 4'hF, 1, 1, 1, 0,  1, 0, 0, 31'd3, 1, 0);
    vecs[3]  = mk("t_lateack", 1, 0, 0, 4'h0, 0, 0, 0, 1,  1, 0, 0, 31'd3, 1, 0);
    vecs[4]  = mk("t_reset2", 0, 0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 0, 31'd0, 0, 0);
    vecs[5]  = mk("t_even2", 1, Tohost, 32'd2, 4'hF, 1, 1, 1, 0,  0, 0, 0, 31'd0, 1, 0);
    vecs[6]  = mk("t_mask3", 1, Tohost, 32'd1, 4'h3, 1, 1, 1, 0,  0, 0, 0, 31'd0, 2, 0);
    vecs[7]  = mk("t_noack", 1, Tohost, 32'd1, 4'hF, 1, 1, 0, 0,  0, 0, 0, 31'd0, 3, 0);
    vecs[8]  = mk("t_wraddr", 1, Tohost + 32'd4, 32'd1, 4'hF, 1, 1, 1, 0,  0, 0, 0, 31'd0, 4, 0);
    vecs[9]  = mk("t_iack", 1, 0, 0, 4'h0, 0, 0, 0, 1,  0, 0, 0, 31'd0, 5, 1);
    vecs[10] = mk("t_pass", 1, Tohost, 32'd1, 4'hF, 1, 1, 1, 1,  1, 1, 0, 31'd0, 6, 2);
    vecs[11] = mk("t_frozen", 1, 0, 0, 4'h0, 0, 0, 0, 1,  1, 1, 0, 31'd0, 6, 2);
    vecs[12] = mk("t_reset3", 0, 0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 0, 31'd0, 0, 0);
    vecs[13] = mk("t_zero", 1, Tohost, 32'd0, 4'hF, 1, 1, 1, 0,  0, 0, 0, 31'd0, 1, 0);
    vecs[14] = mk("t_failhi", 1, Tohost, 32'h8000_0001, 4'hF, 1, 1, 1, 0,
                  1, 0, 0, 31'h4000_0000, 2, 0);
    vecs[15] = mk("t_reset4", 0, 0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 0, 31'd0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rstz, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
            vecs[i].req, vecs[i].wr, vecs[i].ack, vecs[i].iack);
      step();
      chk_all(vecs[i].name, vecs[i].e_done, vecs[i].e_pass, vecs[i].e_tmo,
              vecs[i].e_fc, vecs[i].e_cc, vecs[i].e_fetch);
      chk({vecs[i].name, ".sig_crc"}, crc, 32'h0);
    end

    // 10 idle cycles then pass; counters freeze afterwards.
    reset();
    idle(10);
    chk_all("idle10", 0, 0, 0, 31'd0, 10, 0);
    store(Tohost, 32'd1, 4'hF);
    chk_all("pass11", 1, 1, 0, 31'd0, 11, 0);
    idle(5);
    chk_all("pass11_hold", 1, 1, 0, 31'd0, 11, 0);

    // Watchdog fires on the 20th RUN cycle; disabled instance keeps running.
    reset();
    idle(19);
    chk_all("wd19", 0, 0, 0, 31'd0, 19, 0);
    idle(1);
    chk_all("wd20", 1, 0, 1, 31'd0, 20, 0);
    chk("nw_done20", {31'd0, nw_done}, 32'd0);
    chk("nw_cc20", nw_ccnt, 32'd20);
    idle(5);
    chk_all("wd_hold", 1, 0, 1, 31'd0, 20, 0);
    chk("nw_cc25", nw_ccnt, 32'd25);
    store(Tohost, 32'd1, 4'hF);
    chk_all("wd_late_pass", 1, 0, 1, 31'd0, 20, 0);
    chk("nw_pass", {31'd0, nw_pass}, 32'd1);

    // Tohost on the expiry cycle wins over the watchdog.
    reset();
    idle(19);
    store(Tohost, 32'd1, 4'hF);
    chk_all("wd_tie", 1, 1, 0, 31'd0, 20, 0);

    // 7 fetch acks interleaved with ordinary stores, then pass, then reset.
    reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h0000_2000 + 32'(i * 4), 32'(i), 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      idle(1);
    end
    store(Tohost, 32'd1, 4'hF);
    chk_all("fetch_pass", 1, 1, 0, 31'd0, 15, 7);
    drive(1'b1, 0, 0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("fetch_frozen", fcnt, 32'd7);
    reset();
    chk_all("fetch_reset", 0, 0, 0, 31'd0, 0, 0);
    chk("fetch_reset.sig_crc", crc, 32'h0);

    // Signature region.
    reset();
`ifdef KRONOS_TOHOST_SIG_CRC_EN
    store(32'h0000_1100, 32'h0, 4'hF);
    chk("crc_zero_word", crc, 32'h2144_DF1C);
    store(32'h0000_1200, 32'h1234_5678, 4'hF);
    chk("crc_sig_end_excl", crc, 32'h2144_DF1C);
    store(32'h0000_1104, 32'h1234_5678, 4'h7);
    chk("crc_partial_mask", crc, 32'h2144_DF1C);
    reset();
    chk("crc_reset", crc, 32'h0);
`else
    store(32'h0000_1100, 32'h1234_5678, 4'hF);
    chk("crc_tied", crc, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kronos_tohost_monitor.md
Name: kronos_tohost_monitor

Overview:
- Passive end-of-test monitor on core 0's data bus, downstream of the compliance top's data probe outputs.
- Detects the compliance "tohost" write, decodes the pass or fail code, and counts elapsed cycles and instruction fetches.
- Enforces a watchdog timeout; exposes a sticky result for the simulation harness to sample and stop on.

Parameters:
- TOHOST_ADDR, 32'h0000_1000: word address (byte-aligned, low 2 bits zero) of the tohost location.
- TIMEOUT_CYCLES, 32'd1_000_000: cycles in RUN before the watchdog fires; 0 disables the watchdog.
- SIG_BEGIN, 32'h0000_1100: first byte address of the signature region (inclusive); used only with the optional feature.
- SIG_END, 32'h0000_1200: end of the signature region (exclusive); used only with the optional feature.

Ports:
- clk  input  1  core clock
- rstz  input  1  synchronous active-low reset
- data_addr  input  32  snooped data bus address
- data_wr_data  input  32  snooped write data
- data_mask  input  4  snooped byte mask
- data_wr_en  input  1  snooped write enable
- data_req  input  1  snooped request
- data_ack  input  1  snooped acknowledge
- instr_ack  input  1  snooped instruction fetch acknowledge
- done  output  1  test finished (pass, fail or timeout), sticky
- pass  output  1  test passed, sticky
- timeout  output  1  watchdog fired, sticky
- fail_code  output  31  failing test number (tohost value >> 1)
- cycle_count  output  32  cycles spent in RUN
- fetch_count  output  32  instruction acks seen in RUN
- sig_crc  output  32  signature CRC (optional feature)

Behaviour:
- Reset: one clock only; reset is synchronous and active-low on rstz, sampled at posedge clk.
  - While rstz=0 at a clock edge: state=RUN, all outputs 0, counters 0, sig_crc=32'hFFFF_FFFF internally (reported as 0 via final XOR).
  - Reset asserted mid-test or after done clears everything the next edge.
- Write event: a cycle with data_req & data_wr_en & data_ack all 1.
  - Address, data and mask are sampled in that same cycle; one event per such cycle.
- Tohost event: a write event with data_addr==TOHOST_ADDR and data_mask==4'hF.
  - Partial-mask writes to TOHOST_ADDR are ignored.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal until reset.
- RUN transitions on a tohost event with value V:
  - V==1 -> PASS: done=1, pass=1.
  - V[0]==1 and V!=1 -> FAIL: done=1, pass=0, fail_code=V[31:1].
  - V[0]==0 (including 0): ignored, stay RUN.
- RUN transition on the watchdog: TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 at a clock edge -> TIMEOUT: done=1, timeout=1, pass=0.
- Simultaneous tohost event and watchdog expiry in the same cycle: the tohost event wins; timeout stays 0.
- Output latency: done, pass, fail_code and timeout are registered and update on the edge ending the event cycle (visible 1 cycle later).
- cycle_count: +1 every cycle in RUN, including the terminating cycle; frozen in terminal states; saturates at 32'hFFFF_FFFF.
- fetch_count: +1 per cycle with instr_ack=1 while in RUN; frozen in terminal states; saturates at 32'hFFFF_FFFF.
- Events in terminal states (further tohost writes, acks) have no effect on any output.
- Purely passive: no outputs feed back into the bus.

Optional Feature:
- Macro: KRONOS_TOHOST_SIG_CRC_EN.
- Defined:
  - Every write event in RUN with SIG_BEGIN <= data_addr < SIG_END and data_mask==4'hF folds data_wr_data into a CRC-32.
  - CRC-32 is reflected, poly 32'hEDB8_8320, init 32'hFFFF_FFFF, bytes processed least-significant first, one full word per cycle.
  - sig_crc = running value XOR 32'hFFFF_FFFF; registered, 1-cycle latency; frozen in terminal states.
  - Partial-mask writes in the region are ignored.
- Not defined: sig_crc is tied to 32'h0 and no CRC logic is built; SIG_BEGIN and SIG_END are unused.

Test Plan:
- Reset, 10 idle cycles, then a tohost write (V=1, mask F, req/wr/ack high 1 cycle) -> next cycle done=1, pass=1, timeout=0, cycle_count=11; then 5 more cycles -> cycle_count still 11.
- Tohost write with V=32'h0000_0007 -> done=1, pass=0, fail_code=3; a second write with V=1 afterwards -> no change.
- Tohost write V=2, then V=1 with mask 4'h3 -> done stays 0; then V=1 with mask F -> pass=1.
- TIMEOUT_CYCLES=20, no tohost write -> after 20 cycles in RUN, done=1, timeout=1, cycle_count=20; a tohost write issued on cycle 20 instead -> pass=1, timeout=0.
- 7 instr_ack pulses interleaved with data traffic, then pass; rstz low for 1 cycle -> fetch_count=7 before reset, then all outputs 0 after reset.
- With KRONOS_TOHOST_SIG_CRC_EN: one write of 32'h0 to SIG_BEGIN -> sig_crc=32'h2144_DF1C; a write to SIG_END is excluded -> value unchanged.
